// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer.
// Walks one SPI transaction: a WIDTH-bit address+R/W phase, then either a WIDTH-bit read (data
// shifted out on MISO) or a WIDTH-bit write (data committed to memory). Outputs are decoded from
// the state alone.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   sclkPosEdge  one-clk pulse per SCLK rising edge
//   sclkNegEdge  one-clk pulse per SCLK falling edge
//   csn          conditioned chip select, active-low
//   rw           R/W bit from the shift register MSB (1 = read, 0 = write)
//   addrWE       strobe: latch shift register contents as address
//   parallelLoad strobe: parallel-load the shift register with read data
//   dmWE         strobe: data memory write enable
//   misoBufe     MISO tri-state buffer enable
//   busy         high whenever a transaction is in progress
module spi_fsm #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclkPosEdge,
   input  logic sclkNegEdge,
   input  logic csn,
   input  logic rw,
   output logic addrWE,
   output logic parallelLoad,
   output logic dmWE,
   output logic misoBufe,
   output logic busy
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(WIDTH);

   typedef enum logic [3:0] {
      StIdle,
      StGetAddr,
      StAddrLatch,
      StReadWait,
      StReadLoad,
      StReadShift,
      StWriteShift,
      StWriteCommit,
      StDone
   } stateT;

   stateT           stateQ, stateD;
   logic [CntW-1:0] cntQ, cntD;
   logic            countEdge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StIdle;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   always_comb begin
      stateD    = stateQ;
      countEdge = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (!csn) stateD = StGetAddr;
         end
         StGetAddr: begin
            countEdge = sclkPosEdge;
            // The shift register finishes its last shift on this same clk.
            if (sclkPosEdge && cntQ == LastCnt) stateD = StAddrLatch;
         end
         StAddrLatch: begin
            stateD = rw ? StReadWait : StWriteShift;
         end
         StReadWait: begin
            // One cycle of memory read latency before loading the shift register.
            stateD = StReadLoad;
         end
         StReadLoad: begin
            stateD = StReadShift;
         end
         StReadShift: begin
            countEdge = sclkNegEdge;
            if (sclkNegEdge && cntQ == LastCnt) stateD = StDone;
         end
         StWriteShift: begin
            countEdge = sclkPosEdge;
            if (sclkPosEdge && cntQ == LastCnt) stateD = StWriteCommit;
         end
         StWriteCommit: begin
            stateD = StDone;
         end
         StDone: begin
            if (csn) stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase

      // Chip-select release aborts from anywhere; an aborted write never reaches the commit state.
      if (stateQ != StIdle && csn) stateD = StIdle;
   end

   // Counter restarts on every state entry and saturates rather than wrapping.
   always_comb begin
      cntD = cntQ;
      if (stateD != stateQ) begin
         cntD = '0;
      end else if (countEdge && cntQ < FullCnt) begin
         cntD = cntQ + CntW'(1);
      end
   end

   always_comb begin
      addrWE       = 1'b0;
      parallelLoad = 1'b0;
      dmWE         = 1'b0;
      misoBufe     = 1'b0;
      busy         = (stateQ != StIdle);
      unique case (stateQ)
         StAddrLatch: addrWE = 1'b1;
         StReadLoad: begin
            parallelLoad = 1'b1;
            misoBufe     = 1'b1;
         end
         StReadShift:   misoBufe = 1'b1;
         StWriteCommit: dmWE = 1'b1;
         default: ;
      endcase
   end

endmodule
